mole_field_engine: RTL and testbench
====================================

// Module: mole_field_engine
// PURPOSE
//   Parametrised whack-a-mole game core for NUM_HOLES holes. Holds the game FSM
//   (IDLE/READY/PLAY/OVER), a free-running LFSR mole spawner, per-hole mole
//   lifetime timers, hit/whiff/escape classification, saturating counters and a
//   seconds countdown. Sits between the keyboard hit decoder and the VGA/HEX
//   display logic. Adds per-hole lifetimes and escape counting.
// PARAMETERS
//   NUM_HOLES      5          number of holes, 2..15
//   HIT_W          4          width of hit code; must satisfy 2**HIT_W > NUM_HOLES
//   SCORE_W        8          width of score/whiffs/escapes counters
//   TIME_W         6          width of time_left
//   GAME_SECONDS   30         game length in seconds, < 2**TIME_W
//   TICKS_PER_SEC  50000000   clock cycles per second tick
//   SPAWN_PERIOD   25000000   clock cycles between spawn attempts, >= 1
//   MOLE_LIFE      75000000   cycles a mole stays up if not hit, >= 1
//   LFSR_SEED      16'hACE1   LFSR reset value, nonzero
// PORTS
//   clock       in   1               system clock, all logic posedge
//   resetn      in   1               asynchronous, active-low reset
//   start_game  in   1               level; sampled in READY/OVER
//   hit         in   HIT_W           0 = none, k = hole k-1 struck (level)
//   moles_up    out  NUM_HOLES       bit i = mole visible in hole i
//   game_state  out  2               0 IDLE, 1 READY, 2 PLAY, 3 OVER
//   time_left   out  TIME_W          seconds remaining
//   score       out  SCORE_W         moles hit this game
//   whiffs      out  SCORE_W         strikes on empty holes
//   escapes     out  SCORE_W         moles that timed out
//   hit_valid   out  1               1-cycle pulse: successful hit
//   whiff_valid out  1               1-cycle pulse: strike on empty hole
//   hit_hole    out  HIT_W           hit code of last hit/whiff, held
// BEHAVIOUR
//   Reset (resetn=0, immediate): state IDLE; every output 0; lfsr=LFSR_SEED;
//     prev_hit=0; all internal counters 0. Reset mid-PLAY aborts the game.
//   FSM: IDLE -> READY unconditionally (1 cycle). READY: start_game -> PLAY.
//     PLAY: -> OVER on the edge where time_left goes 1->0. OVER: start_game -> PLAY.
//   Entering PLAY (same edge): score/whiffs/escapes=0, moles_up=0,
//     time_left=GAME_SECONDS, sec_cnt=TICKS_PER_SEC-1, spawn_cnt=SPAWN_PERIOD-1.
//   Entering OVER: moles_up=0, all lifetimes cleared; counters held until next start.
//   Seconds: in PLAY sec_cnt decrements; at 0 reloads and time_left decrements.
//   LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle in all states.
//   Spawn: in PLAY spawn_cnt decrements; at 0 reloads and candidate =
//     lfsr % NUM_HOLES; if moles_up[candidate]==0 it rises next edge with
//     life[candidate]=MOLE_LIFE-1; else attempt is dropped (no retry).
//   Lifetime: while moles_up[i], life[i] decrements each cycle; when life[i]==0
//     the mole drops next edge and escapes increments.
//   Hit detect: new_hit = (hit != prev_hit) && hit != 0 && hit <= NUM_HOLES;
//     prev_hit <= hit every cycle. Holding hit constant strikes once only.
//     Codes > NUM_HOLES ignored entirely. new_hit ignored outside PLAY.
//   Hit result (1-cycle latency, at next edge): if moles_up[hit-1] -> mole drops,
//     score+1, hit_valid=1; else whiffs+1, whiff_valid=1. hit_hole=hit both cases.
//   Simultaneous: hit beats expiry on the same hole (counts hit, not escape).
//     Hit classified on pre-edge moles_up; a spawn into the struck empty hole
//     on the same edge still happens and the strike is a whiff.
//     Spawn candidate whose mole is being hit/expiring this edge is "occupied".
//     Final-second edge: PLAY->OVER wins; pending hit/expiry that edge discarded.
//   Counters saturate at all-ones; never wrap.
//   Pulses are 0 on every cycle not listed above.
// TESTING (NUM_HOLES=5, TICKS_PER_SEC=4, GAME_SECONDS=3, SPAWN_PERIOD=2,
//          MOLE_LIFE=6)
//   1 reset, 2 clocks, start_game=1 -> state IDLE,READY,PLAY; time_left=3;
//     OVER exactly 12 cycles after PLAY entry, moles_up=0.
//   2 force mole in hole 2 up, hit=3 for 5 cycles -> one hit_valid, score=1,
//     moles_up[2]=0, hit_hole=3; no second pulse while held.
//   3 hit=1 with moles_up[0]=0 -> whiff_valid one cycle, whiffs=1, score unchanged.
//   4 no hits: every risen mole drops after 6 cycles, escapes increments per mole;
//     hit on expiry cycle -> score+1, escapes unchanged.
//   5 hit=7 and all hits in READY/OVER -> no pulses, counters unchanged.
//   6 resetn low mid-PLAY with score=2 -> immediate IDLE, score=0, moles_up=0.

Source files
------------

// File: rtl/mole_field_engine.sv
// Whack-a-mole game core: game FSM, LFSR mole spawner, per-hole mole lifetimes,
// hit/whiff/escape classification, saturating counters and a seconds countdown.
module mole_field_engine #(
   parameter int          NUM_HOLES     = 5,
   parameter int          HIT_W         = 4,
   parameter int          SCORE_W       = 8,
   parameter int          TIME_W        = 6,
   parameter int          GAME_SECONDS  = 30,
   parameter int          TICKS_PER_SEC = 50000000,
   parameter int          SPAWN_PERIOD  = 25000000,
   parameter int          MOLE_LIFE     = 75000000,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 start_game,
   input  logic [HIT_W-1:0]     hit,
   output logic [NUM_HOLES-1:0] moles_up,
   output logic [1:0]           game_state,
   output logic [TIME_W-1:0]    time_left,
   output logic [SCORE_W-1:0]   score,
   output logic [SCORE_W-1:0]   whiffs,
   output logic [SCORE_W-1:0]   escapes,
   output logic                 hit_valid,
   output logic                 whiff_valid,
   output logic [HIT_W-1:0]     hit_hole
);
   localparam int SEC_W   = $clog2(TICKS_PER_SEC + 1);
   localparam int SPAWN_W = $clog2(SPAWN_PERIOD + 1);
   localparam int LIFE_W  = $clog2(MOLE_LIFE + 1);

   localparam logic [SEC_W-1:0]   SEC_RELOAD   = SEC_W'(TICKS_PER_SEC - 1);
   localparam logic [SPAWN_W-1:0] SPAWN_RELOAD = SPAWN_W'(SPAWN_PERIOD - 1);
   localparam logic [LIFE_W-1:0]  LIFE_RELOAD  = LIFE_W'(MOLE_LIFE - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READY = 2'd1,
      S_PLAY  = 2'd2,
      S_OVER  = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [15:0]          lfsr_q, lfsr_d;
   logic [HIT_W-1:0]     prev_hit_q, prev_hit_d;
   logic [SEC_W-1:0]     sec_cnt_q, sec_cnt_d;
   logic [SPAWN_W-1:0]   spawn_cnt_q, spawn_cnt_d;
   logic [TIME_W-1:0]    time_left_q, time_left_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [SCORE_W-1:0]   whiffs_q, whiffs_d;
   logic [SCORE_W-1:0]   escapes_q, escapes_d;
   logic [NUM_HOLES-1:0] moles_up_q, moles_up_d;
   logic [LIFE_W-1:0]    life_q [NUM_HOLES];
   logic [LIFE_W-1:0]    life_d [NUM_HOLES];
   logic                 hit_valid_q, hit_valid_d;
   logic                 whiff_valid_q, whiff_valid_d;
   logic [HIT_W-1:0]     hit_hole_q, hit_hole_d;

   logic                 new_hit;
   logic                 last_tick;
   logic [15:0]          spawn_cand;
   logic [NUM_HOLES-1:0] hit_sel;
   logic [NUM_HOLES-1:0] spawn_sel;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      return (&v) ? v : v + SCORE_W'(1);
   endfunction

   assign new_hit    = (hit != prev_hit_q) && (hit != '0) && (hit <= HIT_W'(NUM_HOLES));
   assign last_tick  = (sec_cnt_q == '0) && (time_left_q == TIME_W'(1));
   assign spawn_cand = lfsr_q % 16'(NUM_HOLES);

   // One-hot decodes keep hole selection free of out-of-range vector indexing.
   always_comb begin
      for (int i = 0; i < NUM_HOLES; i++) begin
         hit_sel[i]   = new_hit && (hit == HIT_W'(i + 1));
         spawn_sel[i] = (spawn_cand == 16'(i));
      end
   end

   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no latch is inferred.
      state_d       = state_q;
      lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      prev_hit_d    = hit;
      sec_cnt_d     = sec_cnt_q;
      spawn_cnt_d   = spawn_cnt_q;
      time_left_d   = time_left_q;
      score_d       = score_q;
      whiffs_d      = whiffs_q;
      escapes_d     = escapes_q;
      moles_up_d    = moles_up_q;
      life_d        = life_q;
      hit_valid_d   = 1'b0;
      whiff_valid_d = 1'b0;
      hit_hole_d    = hit_hole_q;

      unique case (state_q)
         S_IDLE: state_d = S_READY;
         S_READY, S_OVER: begin
            if (start_game) begin
               state_d     = S_PLAY;
               score_d     = '0;
               whiffs_d    = '0;
               escapes_d   = '0;
               moles_up_d  = '0;
               time_left_d = TIME_W'(GAME_SECONDS);
               sec_cnt_d   = SEC_RELOAD;
               spawn_cnt_d = SPAWN_RELOAD;
               for (int i = 0; i < NUM_HOLES; i++) life_d[i] = '0;
            end
         end
         S_PLAY: begin
            if (last_tick) begin
               // Game end wins over any hit or expiry pending on this edge.
               state_d     = S_OVER;
               time_left_d = '0;
               sec_cnt_d   = SEC_RELOAD;
               moles_up_d  = '0;
               for (int i = 0; i < NUM_HOLES; i++) life_d[i] = '0;
            end else begin
               if (sec_cnt_q == '0) begin
                  sec_cnt_d   = SEC_RELOAD;
                  time_left_d = time_left_q - TIME_W'(1);
               end else begin
                  sec_cnt_d = sec_cnt_q - SEC_W'(1);
               end

               for (int i = 0; i < NUM_HOLES; i++) begin
                  if (moles_up_q[i]) begin
                     if (hit_sel[i]) begin
                        moles_up_d[i] = 1'b0;
                        score_d       = sat_inc(score_d);
                        hit_valid_d   = 1'b1;
                     end else if (life_q[i] == '0) begin
                        moles_up_d[i] = 1'b0;
                        escapes_d     = sat_inc(escapes_d);
                     end else begin
                        life_d[i] = life_q[i] - LIFE_W'(1);
                     end
                  end
               end

               if (new_hit) begin
                  hit_hole_d = hit;
                  if ((hit_sel & moles_up_q) == '0) begin
                     whiffs_d      = sat_inc(whiffs_q);
                     whiff_valid_d = 1'b1;
                  end
               end

               // Occupancy is judged on pre-edge moles_up, so a hole being hit or
               // expiring on this edge cannot be respawned until the next attempt.
               if (spawn_cnt_q == '0) begin
                  spawn_cnt_d = SPAWN_RELOAD;
                  for (int i = 0; i < NUM_HOLES; i++) begin
                     if (spawn_sel[i] && !moles_up_q[i]) begin
                        moles_up_d[i] = 1'b1;
                        life_d[i]     = LIFE_RELOAD;
                     end
                  end
               end else begin
                  spawn_cnt_d = spawn_cnt_q - SPAWN_W'(1);
               end
            end
         end
      endcase
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q       <= S_IDLE;
         lfsr_q        <= LFSR_SEED;
         prev_hit_q    <= '0;
         sec_cnt_q     <= '0;
         spawn_cnt_q   <= '0;
         time_left_q   <= '0;
         score_q       <= '0;
         whiffs_q      <= '0;
         escapes_q     <= '0;
         moles_up_q    <= '0;
         hit_valid_q   <= 1'b0;
         whiff_valid_q <= 1'b0;
         hit_hole_q    <= '0;
         // NOTE: the lifetime array is plain flops, so it is reset like any other register.
         for (int i = 0; i < NUM_HOLES; i++) life_q[i] <= '0;
      end else begin
         state_q       <= state_d;
         lfsr_q        <= lfsr_d;
         prev_hit_q    <= prev_hit_d;
         sec_cnt_q     <= sec_cnt_d;
         spawn_cnt_q   <= spawn_cnt_d;
         time_left_q   <= time_left_d;
         score_q       <= score_d;
         whiffs_q      <= whiffs_d;
         escapes_q     <= escapes_d;
         moles_up_q    <= moles_up_d;
         hit_valid_q   <= hit_valid_d;
         whiff_valid_q <= whiff_valid_d;
         hit_hole_q    <= hit_hole_d;
         life_q        <= life_d;
      end
   end

   assign moles_up    = moles_up_q;
   assign game_state  = state_q;
   assign time_left   = time_left_q;
   assign score       = score_q;
   assign whiffs      = whiffs_q;
   assign escapes     = escapes_q;
   assign hit_valid   = hit_valid_q;
   assign whiff_valid = whiff_valid_q;
   assign hit_hole    = hit_hole_q;

endmodule

// File: tb/tb_mole_field_engine.sv
// Bench for mole_field_engine: cycle model + scoreboard queue, stimulus tables
// for ignored strikes, and hand-written sequences for the multi-cycle corners.
module tb_mole_field_engine;
   localparam int NH  = 5;
   localparam int HW  = 4;
   localparam int SW  = 8;
   localparam int TW  = 6;
   localparam int GS  = 3;
   localparam int TPS = 4;
   localparam int SP  = 2;
   localparam int ML  = 6;

   logic          clock;
   logic          resetn;
   logic          start_game;
   logic [HW-1:0] hit;
   logic [NH-1:0] moles_up;
   logic [1:0]    game_state;
   logic [TW-1:0] time_left;
   logic [SW-1:0] score;
   logic [SW-1:0] whiffs;
   logic [SW-1:0] escapes;
   logic          hit_valid;
   logic          whiff_valid;
   logic [HW-1:0] hit_hole;

   mole_field_engine #(
      .NUM_HOLES(NH), .HIT_W(HW), .SCORE_W(SW), .TIME_W(TW), .GAME_SECONDS(GS),
      .TICKS_PER_SEC(TPS), .SPAWN_PERIOD(SP), .MOLE_LIFE(ML), .LFSR_SEED(16'hACE1)
   ) dut (
      .clock(clock), .resetn(resetn), .start_game(start_game), .hit(hit),
      .moles_up(moles_up), .game_state(game_state), .time_left(time_left),
      .score(score), .whiffs(whiffs), .escapes(escapes), .hit_valid(hit_valid),
      .whiff_valid(whiff_valid), .hit_hole(hit_hole)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [1:0]    st;
      logic [NH-1:0] up;
      logic [TW-1:0] tl;
      logic [SW-1:0] sc;
      logic [SW-1:0] wh;
      logic [SW-1:0] es;
      logic          hv;
      logic          wv;
      logic [HW-1:0] hh;
   } obs_t;

   typedef struct {
      logic          sg;
      logic [HW-1:0] h;
      logic          exp_hv;
      logic          exp_wv;
      logic [1:0]    exp_st;
   } vec_t;

   obs_t exp_q [$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Reference model of the game, advanced once per clock edge.
   int            m_state, m_sec, m_spawn, m_time, m_sc, m_wh, m_es;
   logic [15:0]   m_lfsr;
   logic [HW-1:0] m_prev, m_hh;
   bit            m_hv, m_wv;
   bit            m_up [NH];
   int            m_life [NH];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v < 255) ? v + 1 : v;
   endfunction

   task automatic model_reset();
      m_state = 0; m_sec = 0; m_spawn = 0; m_time = 0;
      m_sc = 0; m_wh = 0; m_es = 0;
      m_lfsr = 16'hACE1; m_prev = '0; m_hh = '0; m_hv = 0; m_wv = 0;
      for (int i = 0; i < NH; i++) begin
         m_up[i] = 0;
         m_life[i] = 0;
      end
   endtask

   task automatic model_step(input logic sg, input logic [HW-1:0] h);
      logic [15:0] l0;
      bit          old_up [NH];
      bit          nh;
      int          cand;
      l0     = m_lfsr;
      old_up = m_up;
      nh     = (h != m_prev) && (h != '0) && (int'(h) <= NH);
      m_hv   = 0;
      m_wv   = 0;
      if (m_state == 0) begin
         m_state = 1;
      end else if (m_state == 1 || m_state == 3) begin
         if (sg) begin
            m_state = 2; m_sc = 0; m_wh = 0; m_es = 0;
            m_time = GS; m_sec = TPS - 1; m_spawn = SP - 1;
            for (int i = 0; i < NH; i++) begin
               m_up[i] = 0;
               m_life[i] = 0;
            end
         end
      end else if (m_sec == 0 && m_time == 1) begin
         m_state = 3; m_time = 0; m_sec = TPS - 1;
         for (int i = 0; i < NH; i++) begin
            m_up[i] = 0;
            m_life[i] = 0;
         end
      end else begin
         if (m_sec == 0) begin
            m_sec = TPS - 1;
            m_time--;
         end else begin
            m_sec--;
         end
         for (int i = 0; i < NH; i++) begin
            if (old_up[i]) begin
               if (nh && int'(h) == i + 1) begin
                  m_up[i] = 0; m_sc = sat(m_sc); m_hv = 1;
               end else if (m_life[i] == 0) begin
                  m_up[i] = 0; m_es = sat(m_es);
               end else begin
                  m_life[i]--;
               end
            end
         end
         if (nh) begin
            m_hh = h;
            if (!old_up[int'(h) - 1]) begin
               m_wh = sat(m_wh);
               m_wv = 1;
            end
         end
         if (m_spawn == 0) begin
            m_spawn = SP - 1;
            cand = int'(l0 % 16'(NH));
            if (!old_up[cand]) begin
               m_up[cand] = 1;
               m_life[cand] = ML - 1;
            end
         end else begin
            m_spawn--;
         end
      end
      m_prev = h;
      m_lfsr = {l0[14:0], l0[15] ^ l0[13] ^ l0[12] ^ l0[10]};
   endtask

   function automatic obs_t model_obs();
      obs_t o;
      o.st = 2'(m_state);
      for (int i = 0; i < NH; i++) o.up[i] = m_up[i];
      o.tl = TW'(m_time);
      o.sc = SW'(m_sc);
      o.wh = SW'(m_wh);
      o.es = SW'(m_es);
      o.hv = m_hv;
      o.wv = m_wv;
      o.hh = m_hh;
      return o;
   endfunction

   function automatic obs_t dut_obs();
      obs_t o;
      o.st = game_state; o.up = moles_up; o.tl = time_left;
      o.sc = score; o.wh = whiffs; o.es = escapes;
      o.hv = hit_valid; o.wv = whiff_valid; o.hh = hit_hole;
      return o;
   endfunction

   // A strike driven now is judged on the next edge, which must not be the final one.
   function automatic bit strike_ok();
      return (m_state == 2) && !(m_sec == 0 && m_time == 1) && (m_prev == '0);
   endfunction

   function automatic logic restart_sg();
      return (m_state == 1 || m_state == 3);
   endfunction

   // Drive one cycle (called at posedge+1), push the model's expectation, pop at posedge+1.
   task automatic step(input logic sg, input logic [HW-1:0] h);
      obs_t got, want;
      start_game = sg;
      hit        = h;
      model_step(sg, h);
      exp_q.push_back(model_obs());
      @(posedge clock);
      #1;
      got  = dut_obs();
      want = exp_q.pop_front();
      check($sformatf("scoreboard_cycle_%0d", cyc), 64'(got), 64'(want));
      cyc++;
   endtask

   task automatic apply_tbl(input string tag, input vec_t t [6]);
      for (int k = 0; k < 6; k++) begin
         step(t[k].sg, t[k].h);
         check($sformatf("%s_%0d_hit_valid", tag, k), 64'(hit_valid), 64'(t[k].exp_hv));
         check($sformatf("%s_%0d_whiff_valid", tag, k), 64'(whiff_valid), 64'(t[k].exp_wv));
         check($sformatf("%s_%0d_state", tag, k), 64'(game_state), 64'(t[k].exp_st));
         check($sformatf("%s_%0d_score", tag, k), 64'(score), 64'(0));
         check($sformatf("%s_%0d_whiffs", tag, k), 64'(whiffs), 64'(0));
      end
   endtask

   initial begin
      vec_t          over_tbl  [6];
      vec_t          ready_tbl [6];
      logic [HW-1:0] bad_codes [4];
      int            run [NH];
      int            drops, n, pulses, sc0, wh0, es0, tgt;
      bit            found;
      logic [HW-1:0] h;

      over_tbl[0]  = '{1'b0, 4'd1, 1'b0, 1'b0, 2'd3};
      over_tbl[1]  = '{1'b0, 4'd0, 1'b0, 1'b0, 2'd3};
      over_tbl[2]  = '{1'b0, 4'd3, 1'b0, 1'b0, 2'd3};
      over_tbl[3]  = '{1'b0, 4'd7, 1'b0, 1'b0, 2'd3};
      over_tbl[4]  = '{1'b0, 4'd0, 1'b0, 1'b0, 2'd3};
      over_tbl[5]  = '{1'b1, 4'd5, 1'b0, 1'b0, 2'd2};
      ready_tbl[0] = '{1'b0, 4'd2, 1'b0, 1'b0, 2'd1};
      ready_tbl[1] = '{1'b0, 4'd2, 1'b0, 1'b0, 2'd1};
      ready_tbl[2] = '{1'b0, 4'd0, 1'b0, 1'b0, 2'd1};
      ready_tbl[3] = '{1'b0, 4'd9, 1'b0, 1'b0, 2'd1};
      ready_tbl[4] = '{1'b0, 4'd4, 1'b0, 1'b0, 2'd1};
      ready_tbl[5] = '{1'b1, 4'd0, 1'b0, 1'b0, 2'd2};
      bad_codes[0] = 4'd7;
      bad_codes[1] = 4'd6;
      bad_codes[2] = 4'd15;
      bad_codes[3] = 4'd7;

      // Reset: everything zero, IDLE.
      model_reset();
      resetn = 1'b0; start_game = 1'b0; hit = '0;
      #1;
      check("reset_outputs", 64'(dut_obs()), 64'(0));
      repeat (2) @(posedge clock);
      #1;
      resetn = 1'b1;

      // Game start and length: OVER exactly 12 cycles after PLAY entry.
      step(1'b1, '0);
      check("idle_to_ready", 64'(game_state), 64'(1));
      step(1'b1, '0);
      check("ready_to_play", 64'(game_state), 64'(2));
      check("time_left_start", 64'(time_left), 64'(GS));
      for (int i = 0; i < NH; i++) run[i] = 0;
      drops = 0;
      n = 0;
      while (game_state != 2'd3 && n < 40) begin
         step(1'b0, '0);
         n++;
         for (int i = 0; i < NH; i++) begin
            if (moles_up[i]) begin
               run[i]++;
            end else begin
               if (run[i] != 0 && game_state != 2'd3) begin
                  check("mole_up_cycles", 64'(run[i]), 64'(ML));
                  drops++;
               end
               run[i] = 0;
            end
         end
      end
      check("play_to_over_cycles", 64'(n), 64'(12));
      check("over_moles_clear", 64'(moles_up), 64'(0));
      check("escapes_vs_drops", 64'(escapes), 64'(drops));

      // Strikes in OVER ignored; last entry restarts the game.
      apply_tbl("over_tbl", over_tbl);

      // Out-of-range codes in PLAY ignored.
      for (int k = 0; k < 4; k++) begin
         step(1'b0, bad_codes[k]);
         check($sformatf("bad_code_%0d_pulses", k), 64'({hit_valid, whiff_valid}), 64'(0));
         check($sformatf("bad_code_%0d_score", k), 64'(score), 64'(0));
         check($sformatf("bad_code_%0d_whiffs", k), 64'(whiffs), 64'(0));
      end
      step(1'b0, '0);

      // Hold hit=3 on a raised mole in hole 2: exactly one hit.
      found = 0;
      for (int k = 0; k < 3000 && !found; k++) begin
         if (strike_ok() && m_up[2]) found = 1;
         else step(restart_sg(), '0);
      end
      check("find_hole2_up", 64'(found), 64'(1));
      if (found) begin
         sc0 = m_sc;
         pulses = 0;
         for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'd3);
            pulses += int'(hit_valid);
            if (k == 0) begin
               check("hold_first_hit_valid", 64'(hit_valid), 64'(1));
               check("hold_score", 64'(score), 64'(sc0 + 1));
               check("hold_hole2_down", 64'(moles_up[2]), 64'(0));
               check("hold_hit_hole", 64'(hit_hole), 64'(3));
            end
         end
         check("hold_single_pulse", 64'(pulses), 64'(1));
         step(1'b0, '0);
      end

      // Strike on empty hole 0: whiff.
      found = 0;
      for (int k = 0; k < 3000 && !found; k++) begin
         if (strike_ok() && !m_up[0]) found = 1;
         else step(restart_sg(), '0);
      end
      check("find_hole0_empty", 64'(found), 64'(1));
      if (found) begin
         sc0 = m_sc;
         wh0 = m_wh;
         step(1'b0, 4'd1);
         check("whiff_pulse", 64'(whiff_valid), 64'(1));
         check("whiff_no_hit", 64'(hit_valid), 64'(0));
         check("whiff_count", 64'(whiffs), 64'(wh0 + 1));
         check("whiff_score_held", 64'(score), 64'(sc0));
         check("whiff_hit_hole", 64'(hit_hole), 64'(1));
         step(1'b0, 4'd1);
         check("whiff_pulse_ends", 64'(whiff_valid), 64'(0));
         step(1'b0, '0);
      end

      // Strike on the expiry cycle: hit wins, no escape.
      found = 0;
      tgt = 0;
      for (int k = 0; k < 3000 && !found; k++) begin
         if (strike_ok()) begin
            for (int i = 0; i < NH; i++) begin
               if (!found && m_up[i] && m_life[i] == 0) begin
                  found = 1;
                  tgt = i;
               end
            end
         end
         if (!found) step(restart_sg(), '0);
      end
      check("find_expiring_mole", 64'(found), 64'(1));
      if (found) begin
         sc0 = m_sc;
         es0 = m_es;
         step(1'b0, HW'(tgt + 1));
         check("expiry_hit_valid", 64'(hit_valid), 64'(1));
         check("expiry_score", 64'(score), 64'(sc0 + 1));
         check("expiry_escapes_held", 64'(escapes), 64'(es0));
         check("expiry_mole_down", 64'(moles_up[tgt]), 64'(0));
         step(1'b0, '0);
      end

      // Reach score 2 mid-PLAY, then reset asynchronously.
      found = 0;
      for (int k = 0; k < 5000 && !found; k++) begin
         if (m_state == 2 && m_sc == 2) begin
            found = 1;
         end else begin
            h = '0;
            if (strike_ok())
               for (int i = 0; i < NH; i++)
                  if (m_up[i] && h == '0) h = HW'(i + 1);
            step(restart_sg(), h);
         end
      end
      check("reach_score_2", 64'(found), 64'(1));
      check("score_before_reset", 64'(score), 64'(2));
      #3;
      resetn = 1'b0;
      start_game = 1'b0;
      hit = '0;
      #1;
      model_reset();
      check("async_reset_outputs", 64'(dut_obs()), 64'(0));
      @(posedge clock);
      #1;
      check("reset_held_idle", 64'(game_state), 64'(0));
      resetn = 1'b1;

      // Strikes in READY ignored; last entry starts the game.
      step(1'b0, '0);
      check("post_reset_ready", 64'(game_state), 64'(1));
      apply_tbl("ready_tbl", ready_tbl);
      repeat (6) step(1'b0, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
